// File: rtl/seg7_scan_decoder_pkg.sv
// Shared segment-pattern constants and codes for the scanned 7-segment readback path.
package seg7_pkg;

   typedef logic [6:0] seg_t;

   // abcdefg ordering, a in bit 6, active high
   localparam seg_t SEG_0     = 7'b1111110;
   localparam seg_t SEG_1     = 7'b0110000;
   localparam seg_t SEG_2     = 7'b1101101;
   localparam seg_t SEG_3     = 7'b1111001;
   localparam seg_t SEG_4     = 7'b0110011;
   localparam seg_t SEG_5     = 7'b1011011;
   localparam seg_t SEG_6     = 7'b1011111;
   localparam seg_t SEG_7     = 7'b1110000;
   localparam seg_t SEG_8     = 7'b1111111;
   localparam seg_t SEG_9     = 7'b1110011;
   localparam seg_t SEG_DASH  = 7'b0000001;
   localparam seg_t SEG_BLANK = 7'b0000000;

   localparam logic [3:0] CODE_DASH  = 4'hA;
   localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display-bus side (segments + digit enables) and recovered-code side of the scan decoder.
interface seg7_scan_decoder_if
   import seg7_pkg::*;
#(
   parameter int NDIG = 4
);

   seg_t                seg_in;
   logic [NDIG-1:0]     dig_en;
   logic [4*NDIG-1:0]   bcd_out;
   logic [NDIG-1:0]     digit_valid;
   logic                upd;
   logic                err;

   modport master (
      output seg_in, dig_en,
      input  bcd_out, digit_valid, upd, err
   );

   modport slave (
      input  seg_in, dig_en,
      output bcd_out, digit_valid, upd, err
   );

endinterface

// File: rtl/seg7_scan_decoder_pattern_decode.sv
// Combinational abcdefg pattern to code lookup; ok is low for any unrecognised pattern.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  seg_t       seg,
   output logic [3:0] code,
   output logic       ok
);

   always_comb begin
      code = CODE_BLANK;
      ok   = 1'b1;
      case (seg)
         SEG_0:     code = 4'd0;
         SEG_1:     code = 4'd1;
         SEG_2:     code = 4'd2;
         SEG_3:     code = 4'd3;
         SEG_4:     code = 4'd4;
         SEG_5:     code = 4'd5;
         SEG_6:     code = 4'd6;
         SEG_7:     code = 4'd7;
         SEG_8:     code = 4'd8;
         SEG_9:     code = 4'd9;
         SEG_DASH:  code = CODE_DASH;
         SEG_BLANK: code = CODE_BLANK;
         default:   ok   = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a debounced code per digit from a scanned 7-segment bus: one capture per
// settled dwell, and a new code commits after STABLE identical captures of that digit.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NDIG   = 4,
   parameter int SETTLE = 2,
   parameter int STABLE = 2
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   seg7_scan_decoder_if.slave   bus
);

   localparam int DW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam int CW = (STABLE > 1) ? $clog2(STABLE + 1) : 1;
   localparam logic [DW-1:0] SETTLE_C = DW'(SETTLE);
   localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

   logic [NDIG-1:0]          dig_prev_q, dig_prev_d;
   logic [DW-1:0]            dwell_q, dwell_d;
   logic [NDIG-1:0][3:0]     cand_q, cand_d;
   logic [NDIG-1:0][CW-1:0]  cnt_q, cnt_d;
   logic [NDIG-1:0][3:0]     bcd_q, bcd_d;
   logic [NDIG-1:0]          valid_q, valid_d;
   logic                     upd_q, upd_d;
   logic                     err_q, err_d;

   logic                     capture;
   logic                     one_hot;
   logic [3:0]               dec_code;
   logic                     dec_ok;

   seg7_pattern_decode u_decode (
      .seg  (bus.seg_in),
      .code (dec_code),
      .ok   (dec_ok)
   );

   always_comb begin
      dig_prev_d = bus.dig_en;
      if (bus.dig_en == '0) begin
         dwell_d = '0;
      end else if (bus.dig_en != dig_prev_q) begin
         dwell_d = DW'(1);
      end else if (dwell_q == SETTLE_C) begin
         dwell_d = SETTLE_C;
      end else begin
         dwell_d = dwell_q + DW'(1);
      end
      // A fresh dig_en also counts as a new dwell, which matters when SETTLE is 1.
      capture = (dwell_d == SETTLE_C) &&
                ((dwell_q != SETTLE_C) || (bus.dig_en != dig_prev_q));
      one_hot = $onehot(bus.dig_en);
   end

   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      valid_d = valid_q;
      upd_d   = 1'b0;
      err_d   = 1'b0;
      if (capture) begin
         if (!one_hot) begin
            err_d = 1'b1;
         end else begin
            for (int i = 0; i < NDIG; i++) begin
               if (bus.dig_en[i]) begin
                  if (!dec_ok) begin
                     err_d    = 1'b1;
                     cnt_d[i] = '0;
                  end else begin
                     if (dec_code == cand_q[i]) begin
                        cnt_d[i] = (cnt_q[i] == STABLE_C) ? STABLE_C : cnt_q[i] + CW'(1);
                     end else begin
                        cand_d[i] = dec_code;
                        cnt_d[i]  = CW'(1);
                     end
                     if ((cnt_d[i] == STABLE_C) && ((dec_code != bcd_q[i]) || !valid_q[i])) begin
                        bcd_d[i]   = dec_code;
                        valid_d[i] = 1'b1;
                        upd_d      = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_prev_q <= '0;
         dwell_q    <= '0;
         cand_q     <= '0;
         cnt_q      <= '0;
         bcd_q      <= {NDIG{CODE_BLANK}};
         valid_q    <= '0;
         upd_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         dig_prev_q <= dig_prev_d;
         dwell_q    <= dwell_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         valid_q    <= valid_d;
         upd_q      <= upd_d;
         err_q      <= err_d;
      end
   end

   assign bus.bcd_out     = bcd_q;
   assign bus.digit_valid = valid_q;
   assign bus.upd         = upd_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed scans push expected upd/err events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_seg7_scan_decoder;
   import seg7_pkg::*;

   typedef struct {
      bit          is_err;
      logic [15:0] bcd;
      logic [3:0]  valid;
   } exp_t;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   exp_t exp_q[$];

   seg7_scan_decoder_if #(.NDIG(4)) bus ();

   seg7_scan_decoder #(.NDIG(4), .SETTLE(2), .STABLE(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_ev(input bit is_err, input logic [15:0] b, input logic [3:0] v);
      exp_t e;
      e.is_err = is_err;
      e.bcd    = b;
      e.valid  = v;
      exp_q.push_back(e);
   endtask

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Drives en/seg for n rising edges, then leaves the bus idle.
   task automatic visit(input logic [3:0] en, input seg_t s, input int n);
      @(negedge clk);
      bus.dig_en = en;
      bus.seg_in = s;
      repeat (n) @(negedge clk);
      bus.dig_en = '0;
   endtask

   always @(negedge clk) begin
      if (rst_n && (bus.upd || bus.err)) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got upd=%b err=%b bcd=%h valid=%b, required none",
                     bus.upd, bus.err, bus.bcd_out, bus.digit_valid);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({bus.upd, bus.err} !== {!e.is_err, e.is_err} ||
                bus.bcd_out !== e.bcd || bus.digit_valid !== e.valid) begin
               fails++;
               $display("FAIL event: got upd=%b err=%b bcd=%h valid=%b, required upd=%b err=%b bcd=%h valid=%b",
                        bus.upd, bus.err, bus.bcd_out, bus.digit_valid,
                        !e.is_err, e.is_err, e.bcd, e.valid);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.dig_en = '0;
      bus.seg_in = SEG_BLANK;
      repeat (3) @(negedge clk);
      check16("reset_bcd", bus.bcd_out, 16'hFFFF);
      check16("reset_valid", {12'h0, bus.digit_valid}, 16'h0000);
      check16("reset_upd_err", {14'h0, bus.upd, bus.err}, 16'h0000);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // two full scans of 1,2,3,4; commits land on the second visit
      visit(4'b0001, SEG_1, 4);
      visit(4'b0010, SEG_2, 4);
      visit(4'b0100, SEG_3, 4);
      visit(4'b1000, SEG_4, 4);
      expect_ev(0, 16'hFFF1, 4'b0001);
      expect_ev(0, 16'hFF21, 4'b0011);
      expect_ev(0, 16'hF321, 4'b0111);
      expect_ev(0, 16'h4321, 4'b1111);
      visit(4'b0001, SEG_1, 4);
      visit(4'b0010, SEG_2, 4);
      visit(4'b0100, SEG_3, 4);
      visit(4'b1000, SEG_4, 4);
      check16("scan_bcd", bus.bcd_out, 16'h4321);
      check16("scan_valid", {12'h0, bus.digit_valid}, 16'h000F);

      // glitch: 7, 2, 7 must not disturb the committed 2; a second 7 in a row commits
      visit(4'b0010, SEG_7, 4);
      visit(4'b0010, SEG_2, 4);
      visit(4'b0010, SEG_7, 4);
      check16("glitch_hold", bus.bcd_out, 16'h4321);
      expect_ev(0, 16'h4371, 4'b1111);
      visit(4'b0010, SEG_7, 4);
      check16("glitch_commit", bus.bcd_out, 16'h4371);

      // unrecognised pattern on digit 2, then two good visits of 5
      expect_ev(1, 16'h4371, 4'b1111);
      visit(4'b0100, 7'b0101010, 4);
      expect_ev(1, 16'h4371, 4'b1111);
      visit(4'b0100, 7'b0101010, 4);
      visit(4'b0100, SEG_5, 4);
      expect_ev(0, 16'h4571, 4'b1111);
      visit(4'b0100, SEG_5, 4);

      // two digits enabled at once: a single err for the whole dwell
      expect_ev(1, 16'h4571, 4'b1111);
      visit(4'b0011, SEG_1, 5);

      // dash on digit 0
      visit(4'b0001, SEG_DASH, 4);
      expect_ev(0, 16'h457A, 4'b1111);
      visit(4'b0001, SEG_DASH, 4);

      // SETTLE-1 dwell gives no capture, so it takes two full dwells to commit 9
      visit(4'b1000, SEG_9, 1);
      visit(4'b1000, SEG_9, 2);
      check16("short_dwell_hold", bus.bcd_out, 16'h457A);
      expect_ev(0, 16'h957A, 4'b1111);
      visit(4'b1000, SEG_9, 2);
      repeat (2) @(negedge clk);
      check16("dwell_commit", bus.bcd_out, 16'h957A);

      // reset during a dwell that would otherwise capture an err
      @(negedge clk);
      bus.dig_en = 4'b0011;
      bus.seg_in = SEG_8;
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      bus.dig_en = '0;
      check16("midreset_bcd", bus.bcd_out, 16'hFFFF);
      check16("midreset_valid", {12'h0, bus.digit_valid}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      visit(4'b0001, SEG_3, 4);
      expect_ev(0, 16'hFFF3, 4'b0001);
      visit(4'b0001, SEG_3, 4);

      repeat (5) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_events: got %0d unseen, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side companion to the BCD-to-7-segment decoder. It monitors a multiplexed (scanned) 7-segment display bus, made of segment lines plus one-hot digit enables, and recovers a debounced BCD code for every digit position. It sits between display-bus pins or a display-driver output and any logic that must read back what is shown, for example self-check or LC3 console mirroring.

## Interface
Parameters:
- NDIG, 4: number of scanned digit positions.
- SETTLE, 2: consecutive clocks a digit enable must be held before its segments are sampled (≥1).
- STABLE, 2: consecutive identical captures of a digit needed to commit a new code (≥1).

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- seg_in  in  7: segment lines abcdefg, a = bit 6, active high.
- dig_en  in  NDIG: digit select; one-hot when a digit is driven, zero when idle.
- bcd_out  out  4*NDIG: committed code per digit; digit i is at [4i+3:4i].
- digit_valid  out  NDIG: digit i has been committed at least once since reset.
- upd  out  1: one-cycle pulse when any bcd_out nibble changes.
- err  out  1: one-cycle pulse on a rejected capture.

## Operation
- Pattern decode:
  - 0 through 9 use the standard abcdefg patterns: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1110011.
  - 0000001 (dash) decodes to code 4'hA.
  - 0000000 (blank) decodes to code 4'hF.
  - Any other pattern is unrecognised.
- Dwell counter:
  - Counts consecutive edges at which dig_en is nonzero and equal to its value at the previous edge.
  - Resets to 1 when dig_en changes to a nonzero value.
  - Resets to 0 when dig_en is zero.
  - Saturates at SETTLE.
- Capture edge: the edge at which the dwell counter reaches SETTLE. There is exactly one capture per dwell, regardless of dwell length.
- At a capture edge:
  - If dig_en is not one-hot: err = 1, no state change.
  - Else if the pattern is unrecognised: err = 1, cand_cnt[i] = 0, committed code unchanged.
  - Else, with decoded code c for digit i:
    - If c == cand[i], cand_cnt[i] increments (saturating at STABLE). Otherwise cand[i] = c and cand_cnt[i] = 1.
    - When cand_cnt[i] becomes STABLE on this edge, the commit is evaluated: if c != bcd_out[i] or digit_valid[i] == 0, then bcd_out[i] = c, digit_valid[i] = 1, upd = 1.
- seg_in changing mid-dwell after the capture edge is ignored.
- Captures of a digit are counted only for that digit. Other digits' candidate state is untouched.

## Timing
- All outputs are registered.
- A capture's effects (bcd_out, digit_valid, upd, err) appear on the capture edge itself and are visible in the following cycle.
- Latency from a new dig_en value to err or upd is SETTLE clocks, counting the first edge at which the new value is sampled.
- Latency for a digit's new value to commit is STABLE scan visits of that digit.
- upd and err are mutually exclusive and last one cycle.
- Reset values:
  - bcd_out is all 4'hF.
  - digit_valid = 0, upd = 0, err = 0.
  - Dwell counter, cand and cand_cnt are cleared to 0.
- Reset asserted mid-dwell aborts the capture. After release, the dwell counter restarts from the current dig_en.
- dig_en changing on the same edge that would have been the capture edge means no capture occurs; the counter restarts at 1.

## Structure
- Package seg7_pkg holds:
  - segment pattern constants SEG_0 through SEG_9, SEG_DASH and SEG_BLANK;
  - codes CODE_DASH = 4'hA and CODE_BLANK = 4'hF;
  - a typedef for the 7-bit segment vector.
- Sub-module seg7_pattern_decode is combinational: seg[6:0] in, code[3:0] and ok out. It is shared with any future segment-bus checker.
- Top level holds:
  - the dwell counter and a dig_en previous-value register;
  - a one-hot check;
  - per-digit cand, cand_cnt and committed registers;
  - the upd and err pulse registers.

## Test plan
- Reset: with rst_n low, bcd_out = 16'hFFFF and digit_valid = 0. Release, hold dig_en = 0 for 10 cycles: no upd and no err.
- Scan digits 0 to 3 showing 1, 2, 3, 4 (dwell 4 clocks each, 2 full scans): upd on the second visit of each digit; bcd_out = 16'h4321; digit_valid = 4'hF.
- Glitch rejection: in 3 consecutive visits digit 1 shows 7, then 2, then 7. No change from the 2 (0010 stays committed). Two consecutive 7s are needed, so a fourth visit showing 7 commits 7 and pulses upd.
- Unrecognised pattern 0101010 on digit 2: err pulses once per visit, bcd_out[11:8] is unchanged, and after two good visits it commits again.
- dig_en = 4'b0011 held for 5 clocks: exactly one err pulse, no updates. Dash 0000001 on digit 0 commits 4'hA.
- Dwell boundary: dig_en held exactly SETTLE−1 clocks gives no capture; held exactly SETTLE clocks gives one capture. Reset pulsed mid-dwell gives no err or upd and restores the reset values.
